// File: rtl/baud_gen_pkg.sv
// Shared types and helpers for the fractional baud generator.
//   state_t      : generator FSM state (IDLE / RUN)
//   deff_clamp() : effective integer divisor (zero is clamped to one)
//   os_cnt_width(): width of the oversample counter for a given OS_RATE
package baud_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A divisor of zero would stall the counter; treat it as one clock per tick.
    function automatic int unsigned deff_clamp(input int unsigned div);
        return (div == 0) ? 32'd1 : div;
    endfunction

    function automatic int unsigned os_cnt_width(input int unsigned rate);
        return (rate < 2) ? 32'd1 : 32'($clog2(rate));
    endfunction

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional phase accumulator. Each step adds div_frac_i into the
// accumulator; carry_o flags that the current period must be stretched by
// one clock so the long-run average period includes the fraction.
//   clk, reset   : clock, asynchronous active-high reset
//   step_i       : advance the phase (one per os_tick)
//   clear_i      : zero the phase (idle, re-phase); wins over step_i
//   div_frac_i   : fractional divisor F
//   carry_o      : overflow of acc + F, valid in the cycle step_i is high
module baud_frac_accum #(
    parameter int unsigned FRAC_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_i,
    input  logic                 clear_i,
    input  logic [FRAC_BITS-1:0] div_frac_i,
    output logic                 carry_o
);

    logic [FRAC_BITS-1:0] acc_q;
    logic [FRAC_BITS:0]   sum_d;

    assign sum_d   = {1'b0, acc_q} + {1'b0, div_frac_i};
    assign carry_o = sum_d[FRAC_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (step_i) begin
            acc_q <= sum_d[FRAC_BITS-1:0];
        end
    end

endmodule

// File: rtl/frac_baud_generator.sv
// Runtime-programmable baud tick generator with fractional divisor.
// Average os_tick period is Deff + F/2^FRAC_BITS clocks; bit_tick marks
// every OS_RATE-th os_tick. sync_clear re-phases to an RX start edge.
// Optional feature macro: BAUD_MIDBIT_TICK_EN adds the mid_tick output.
//   clk, reset  : clock, asynchronous active-high reset
//   enable      : 1 = run, 0 = idle with all state cleared
//   sync_clear  : re-phase pulse
//   div_int     : integer divisor D (0 treated as 1)
//   div_frac    : fractional divisor F
//   os_tick     : 1-cycle oversample tick
//   bit_tick    : os_tick that closes a bit (os_cnt == OS_RATE-1)
//   running     : generator is in RUN
//   mid_tick    : os_tick at the bit mid-point (BAUD_MIDBIT_TICK_EN only)
module frac_baud_generator
    import baud_gen_pkg::*;
#(
    parameter int unsigned BITS      = 16,
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync_clear,
    input  logic [BITS-1:0]      div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    output logic                 os_tick,
    output logic                 bit_tick,
`ifdef BAUD_MIDBIT_TICK_EN
    output logic                 mid_tick,
`endif
    output logic                 running
);

    localparam int unsigned OS_CNT_W = os_cnt_width(OS_RATE);
    localparam logic [OS_CNT_W-1:0] OS_LAST = OS_CNT_W'(OS_RATE - 1);

    state_t                state_q;
    logic [BITS-1:0]       cnt_q;
    logic [OS_CNT_W-1:0]   os_cnt_q;
    logic [BITS-1:0]       reload_base;
    logic                  carry;
    logic                  acc_clear;

    // Deff-1; adding the carry can reach at most 2^BITS-1, so no overflow.
    assign reload_base = BITS'(deff_clamp(32'(div_int)) - 32'd1);

    // Tick is a decode of registered state, only gated by the control inputs.
    assign os_tick  = (state_q == RUN) & enable & ~sync_clear & (cnt_q == '0);
    assign bit_tick = os_tick & (os_cnt_q == OS_LAST);
    assign running  = (state_q == RUN);

`ifdef BAUD_MIDBIT_TICK_EN
    localparam logic [OS_CNT_W-1:0] OS_MID = OS_CNT_W'(OS_RATE / 2 - 1);
    assign mid_tick = os_tick & (os_cnt_q == OS_MID);
`endif

    assign acc_clear = (state_q != RUN) | ~enable | sync_clear;

    baud_frac_accum #(
        .FRAC_BITS(FRAC_BITS)
    ) u_frac_accum (
        .clk       (clk),
        .reset     (reset),
        .step_i    (os_tick),
        .clear_i   (acc_clear),
        .div_frac_i(div_frac),
        .carry_o   (carry)
    );

    // FSM plus cycle and oversample counters; priority enable=0 > start/sync > tick > count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            os_cnt_q <= '0;
        end else if (!enable) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            os_cnt_q <= '0;
        end else if ((state_q == IDLE) || sync_clear) begin
            state_q  <= RUN;
            cnt_q    <= reload_base;
            os_cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q    <= reload_base + BITS'(carry);
            os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_CNT_W'(1);
        end else begin
            cnt_q    <= cnt_q - BITS'(1);
        end
    end

endmodule

// File: tb/tb_frac_baud_generator.sv
// Randomized check of frac_baud_generator against an absolute-time model:
// the model predicts the cycle number of the next os_tick from the divisor
// and the running sum of fractional parts, and counts ticks since re-phase.
module tb_frac_baud_generator;

    localparam int unsigned BITS      = 16;
    localparam int unsigned FRAC_BITS = 4;
    localparam int unsigned OS_RATE   = 16;
    localparam longint      SCALE     = longint'(1) << FRAC_BITS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 sync_clear;
    logic [BITS-1:0]      div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic                 os_tick;
    logic                 bit_tick;
    logic                 running;
`ifdef BAUD_MIDBIT_TICK_EN
    logic                 mid_tick;
`endif

    frac_baud_generator #(
        .BITS     (BITS),
        .FRAC_BITS(FRAC_BITS),
        .OS_RATE  (OS_RATE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sync_clear(sync_clear),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick),
`ifdef BAUD_MIDBIT_TICK_EN
        .mid_tick  (mid_tick),
`endif
        .running   (running)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;

    // Reference model state
    bit     m_run   = 1'b0;
    longint m_next  = 0;   // cycle index of the next expected os_tick
    longint m_ticks = 0;   // os_ticks since last (re)start
    longint m_phase = 0;   // sum of fractional parts since last (re)start
    longint cyc     = 0;
    longint tick_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, compare, then advance the model
    // to the state the DUT will hold after the following posedge.
    task automatic step(input bit en, input bit sc, input int d, input int f);
        bit     e_os;
        bit     e_bit;
        bit     e_mid;
        longint deff;
        longint carry;
        @(negedge clk);
        enable     = en;
        sync_clear = sc;
        div_int    = BITS'(d);
        div_frac   = FRAC_BITS'(f);
        #1;
        deff  = (d == 0) ? 1 : longint'(d);
        e_os  = m_run && en && !sc && (cyc == m_next);
        e_bit = e_os && ((m_ticks % OS_RATE) == OS_RATE - 1);
        e_mid = e_os && ((m_ticks % OS_RATE) == OS_RATE / 2 - 1);
        check("running", 32'(running), 32'(m_run));
        check("os_tick", 32'(os_tick), 32'(e_os));
        check("bit_tick", 32'(bit_tick), 32'(e_bit));
`ifdef BAUD_MIDBIT_TICK_EN
        check("mid_tick", 32'(mid_tick), 32'(e_mid));
`else
        e_mid = 1'b0;
`endif
        if (os_tick === 1'b1) tick_q.push_back(cyc);
        if (!en) begin
            m_run = 1'b0;
        end else if (!m_run || sc) begin
            m_run   = 1'b1;
            m_next  = cyc + deff;
            m_ticks = 0;
            m_phase = 0;
        end else if (e_os) begin
            carry   = ((m_phase + f) / SCALE) - (m_phase / SCALE);
            m_phase = m_phase + f;
            m_next  = cyc + deff + carry;
            m_ticks = m_ticks + 1;
        end
        cyc++;
    endtask

    task automatic run_steps(input int n, input int d, input int f);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, d, f);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10, 0);
    endtask

    // Reset asserted between clock edges; outputs must drop at once.
    task automatic async_reset();
        @(negedge clk);
        enable     = 1'b0;
        sync_clear = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_os_tick", 32'(os_tick), 32'd0);
        check("rst_bit_tick", 32'(bit_tick), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        m_run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int pick_d();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return int'($urandom_range(3, 12));
            4:       return 10;
            default: return int'($urandom_range(13, 40));
        endcase
    endfunction

    initial begin
        int d;
        int f;
        int len;
        reset      = 1'b1;
        enable     = 1'b0;
        sync_clear = 1'b0;
        div_int    = '0;
        div_frac   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_os_tick", 32'(os_tick), 32'd0);
        check("reset_bit_tick", 32'(bit_tick), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        reset = 1'b0;
        idle_steps(3);

        // Integer divisor 10: period 10, bit_tick every 160 cycles
        run_steps(400, 10, 0);
        idle_steps(2);

        // Fraction 8/16: any 16 consecutive periods span 168 cycles
        tick_q.delete();
        run_steps(700, 10, 8);
        for (int i = 0; i + 16 < tick_q.size(); i += 7)
            check("span16", 32'(tick_q[i+16] - tick_q[i]), 32'd168);
        idle_steps(2);

        // Zero and unit divisor: tick every enabled cycle
        run_steps(60, 0, 0);
        idle_steps(1);
        run_steps(60, 1, 0);
        idle_steps(1);

        // Re-phase mid-period, then divisor change mid-period
        run_steps(25, 10, 0);
        step(1'b1, 1'b1, 10, 0);
        run_steps(200, 10, 0);
        run_steps(5, 10, 0);
        run_steps(60, 20, 0);

        // Asynchronous reset mid-run, then the plain divisor-10 run again
        async_reset();
        run_steps(200, 10, 0);

        // Randomized segments
        for (int s = 0; s < 18; s++) begin
            d   = pick_d();
            f   = int'($urandom_range(0, 15));
            len = int'($urandom_range(100, 350));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 199) == 0) d = pick_d();
                if ($urandom_range(0, 199) == 0) f = int'($urandom_range(0, 15));
                step($urandom_range(0, 99) != 0, $urandom_range(0, 149) == 0, d, f);
            end
        end
        async_reset();
        run_steps(30, 3, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
